// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: pipelined pre-add / multiply / accumulate engine with N-sample
// dot products, early termination, saturation, output rounding and
// valid/ready streaming. Stages: S1 input regs, S2 pre-adder, S3 multiplier,
// S4 accumulator + output register.
module dsp_mac_pipe #(
    parameter int unsigned A_WIDTH     = 18,
    parameter int unsigned B_WIDTH     = 18,
    parameter int unsigned P_WIDTH     = 48,
    parameter int unsigned ACC_LEN     = 8,
    parameter int unsigned SATURATE    = 1,
    parameter int unsigned ROUND_SHIFT = 0
) (
    input  logic                                 CLK,
    input  logic                                 RST_N,
    input  logic                                 CE,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 in_last,
    input  logic [1:0]                           MODE,
    input  logic signed [A_WIDTH-1:0]            A,
    input  logic signed [B_WIDTH-1:0]            B,
    input  logic signed [B_WIDTH-1:0]            D,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [P_WIDTH-1:0]            P,
    output logic                                 OVF,
    output logic [$clog2(ACC_LEN+1)-1:0]         CNT
);

    localparam int unsigned AW  = A_WIDTH;
    localparam int unsigned BW  = B_WIDTH;
    localparam int unsigned PRW = B_WIDTH + 1;
    localparam int unsigned MW  = A_WIDTH + B_WIDTH + 1;
    localparam int unsigned PW  = P_WIDTH;
    localparam int unsigned SW  = P_WIDTH + 1;
    localparam int unsigned CW  = $clog2(ACC_LEN + 1);
    localparam int unsigned RS  = ROUND_SHIFT;

    localparam logic signed [PW-1:0] MAXV = {1'b0, {(PW-1){1'b1}}};
    localparam logic signed [PW-1:0] MINV = {1'b1, {(PW-1){1'b0}}};

    // The accumulator must hold at least one full-precision product.
    if (P_WIDTH < A_WIDTH + B_WIDTH + 1) begin : g_bad_p_width
        $error("dsp_mac_pipe: P_WIDTH must be >= A_WIDTH+B_WIDTH+1");
    end
    if (ACC_LEN < 1) begin : g_bad_acc_len
        $error("dsp_mac_pipe: ACC_LEN must be >= 1");
    end

    // Stage registers
    logic                 r_s1_v, r_s1_last;
    logic [1:0]           r_s1_mode;
    logic signed [AW-1:0] r_s1_a;
    logic signed [BW-1:0] r_s1_b, r_s1_d;
    logic                 r_s2_v, r_s2_last;
    logic signed [AW-1:0] r_s2_a;
    logic signed [PRW-1:0] r_s2_pre;
    logic                 r_s3_v, r_s3_last;
    logic signed [MW-1:0] r_s3_m;

    // Accumulator state and output register
    logic signed [PW-1:0] r_acc;
    logic [CW-1:0]        r_cnt;
    logic                 r_sticky;
    logic                 r_out_valid;
    logic signed [PW-1:0] r_p;
    logic                 r_ovf;
    logic [CW-1:0]        r_cnt_o;

    // Combinational datapath
    logic                  w_adv;
    logic signed [PRW-1:0] w_b_ext, w_d_ext, w_pre;
    logic signed [MW-1:0]  w_prod;
    logic signed [PW-1:0]  w_m_ext, w_acc_base, w_acc_next, w_rnd;
    logic signed [SW-1:0]  w_sum;
    logic                  w_acc_ovf, w_rnd_ovf, w_term;
    logic [CW-1:0]         w_cnt_next;

    // Whole pipe advances only when enabled and the output slot can move.
    assign w_adv    = CE && !(r_out_valid && !out_ready);
    assign in_ready = w_adv;

    assign out_valid = r_out_valid;
    assign P         = r_p;
    assign OVF       = r_ovf;
    assign CNT       = r_cnt_o;

    assign w_b_ext = PRW'(r_s1_b);
    assign w_d_ext = PRW'(r_s1_d);

    // Pre-adder select; one extra bit so D+B and D-B never wrap.
    always_comb begin
        w_pre = w_b_ext;
        case (r_s1_mode)
            2'b01:   w_pre = w_d_ext + w_b_ext;
            2'b10:   w_pre = w_d_ext - w_b_ext;
            default: w_pre = w_b_ext;
        endcase
    end

    assign w_prod = MW'(r_s2_a) * MW'(r_s2_pre);

    // An empty counter marks the first sample of a dot product.
    assign w_m_ext    = PW'(r_s3_m);
    assign w_acc_base = (r_cnt == '0) ? '0 : r_acc;
    assign w_sum      = SW'(w_acc_base) + SW'(w_m_ext);
    assign w_acc_ovf  = w_sum[PW] ^ w_sum[PW-1];

    // Clamp or wrap the widened sum back into the accumulator range.
    always_comb begin
        w_acc_next = w_sum[PW-1:0];
        if (w_acc_ovf && SATURATE != 0) begin
            w_acc_next = w_sum[PW] ? MINV : MAXV;
        end
    end

    assign w_cnt_next = r_cnt + CW'(1);
    assign w_term     = r_s3_v && (r_s3_last || (w_cnt_next == CW'(ACC_LEN)));

    // Optional round-half-up arithmetic shift at the output.
    if (RS == 0) begin : g_no_round
        assign w_rnd     = w_acc_next;
        assign w_rnd_ovf = 1'b0;
    end else begin : g_round
        localparam logic signed [SW-1:0] HALF = SW'(1) << (RS - 1);
        logic signed [SW-1:0] w_rsum, w_rsh;
        assign w_rsum    = SW'(w_acc_next) + HALF;
        assign w_rsh     = w_rsum >>> RS;
        assign w_rnd_ovf = w_rsh[PW] ^ w_rsh[PW-1];
        assign w_rnd     = (w_rnd_ovf && SATURATE != 0) ? (w_rsh[PW] ? MINV : MAXV)
                                                         : w_rsh[PW-1:0];
    end

    // S1..S3 pipeline registers with per-stage valid.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_s1_v    <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_mode <= '0;
            r_s1_a    <= '0;
            r_s1_b    <= '0;
            r_s1_d    <= '0;
            r_s2_v    <= 1'b0;
            r_s2_last <= 1'b0;
            r_s2_a    <= '0;
            r_s2_pre  <= '0;
            r_s3_v    <= 1'b0;
            r_s3_last <= 1'b0;
            r_s3_m    <= '0;
        end else if (w_adv) begin
            r_s1_v    <= in_valid;
            r_s1_last <= in_last;
            r_s1_mode <= MODE;
            r_s1_a    <= A;
            r_s1_b    <= B;
            r_s1_d    <= D;
            r_s2_v    <= r_s1_v;
            r_s2_last <= r_s1_last;
            r_s2_a    <= r_s1_a;
            r_s2_pre  <= w_pre;
            r_s3_v    <= r_s2_v;
            r_s3_last <= r_s2_last;
            r_s3_m    <= w_prod;
        end
    end

    // Accumulator, sample counter and sticky overflow; cleared on termination.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else if (w_adv && r_s3_v) begin
            if (w_term) begin
                r_acc    <= '0;
                r_cnt    <= '0;
                r_sticky <= 1'b0;
            end else begin
                r_acc    <= w_acc_next;
                r_cnt    <= w_cnt_next;
                r_sticky <= r_sticky | w_acc_ovf;
            end
        end
    end

    // Output register: load on termination, drop valid once consumed.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_out_valid <= 1'b0;
            r_p         <= '0;
            r_ovf       <= 1'b0;
            r_cnt_o     <= '0;
        end else if (w_adv) begin
            if (w_term) begin
                r_out_valid <= 1'b1;
                r_p         <= w_rnd;
                r_ovf       <= r_sticky | w_acc_ovf | w_rnd_ovf;
                r_cnt_o     <= w_cnt_next;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/dsp_mac_pipe.md
Name: dsp_mac_pipe

Overview:
- Parametrised, pipelined multiply-accumulate engine. It is the next generation of the team's fixed 18x18 DSP slice model.
- It adds:
  - configurable operand and accumulator widths
  - N-sample dot-product accumulation with early termination
  - saturation and rounding
  - valid/ready streaming with backpressure
- It sits between the sample streaming front-end and the filter/correlator datapaths.

Parameters:
- A_WIDTH, 18, signed width of A.
- B_WIDTH, 18, signed width of B and D (pre-adder operands).
- P_WIDTH, 48, accumulator and output width. Elaboration must fail if P_WIDTH < A_WIDTH+B_WIDTH+1.
- ACC_LEN, 8, products per dot product (>=1).
- SATURATE, 1, 1 = clamp on overflow; 0 = two's-complement wrap.
- ROUND_SHIFT, 0, arithmetic right shift applied at the output, round-half-up (0 = none).

Ports:
- CLK  in  1  clock.
- RST_N  in  1  synchronous, active-low reset.
- CE  in  1  global clock enable; 0 freezes all state.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input can be accepted.
- in_last  in  1  ends the current dot product with this sample.
- MODE  in  2  pre-adder select: 00 pre=B, 01 pre=D+B, 10 pre=D-B, 11 pre=B.
- A  in  A_WIDTH  signed multiplicand.
- B  in  B_WIDTH  signed pre-adder operand.
- D  in  B_WIDTH  signed pre-adder operand.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- P  out  P_WIDTH  signed result.
- OVF  out  1  overflow/saturation occurred in this result.
- CNT  out  clog2(ACC_LEN+1)  number of samples in this result.

Behaviour:
- **Reset.** While RST_N=0 at a CLK edge, the following are all cleared to 0: stage valids, accumulator, sample counter, sticky overflow, P, OVF, CNT and out_valid. Inputs are ignored in that cycle.
- **Advance condition.**
  - adv = CE && !(out_valid && !out_ready).
  - in_ready = adv (combinational).
  - A sample is accepted on an edge where in_valid && in_ready.
  - When adv=0, every pipeline register, the accumulator, the counter and the output register hold.
- **Pipeline** (each stage carries a valid bit; bubbles propagate as valid=0):
  - S1: registers A, B, D, MODE and in_last.
  - S2: pre-adder, result width B_WIDTH+1, sign-extended, no wrap. A is delayed to match.
  - S3: product M = A*pre, full precision A_WIDTH+B_WIDTH+1, sign-extended to P_WIDTH.
  - S4: accumulate. sum = (first ? 0 : acc) + M, computed at P_WIDTH+1 bits.
- **Accumulator overflow.**
  - Overflow in the accumulation sets the sticky overflow flag.
  - SATURATE=1: the accumulator clamps to +(2^(P_WIDTH-1)-1) or -2^(P_WIDTH-1).
  - SATURATE=0: the accumulator wraps.
- **Counter and termination.**
  - The counter increments on each valid S4 sample.
  - A dot product terminates when the count reaches ACC_LEN or when the sample's in_last=1, whichever comes first.
- **On termination (same edge):**
  - P is loaded with round(sum).
  - CNT is loaded with the sample count.
  - OVF is loaded with the sticky flag OR'd with this edge's overflow.
  - out_valid is set to 1.
  - The accumulator, counter and sticky flag reset, and the next valid sample is treated as first.
- **Rounding** (ROUND_SHIFT=R>0): P = (acc + 2^(R-1)) >>> R, computed at P_WIDTH+1 bits. A carry beyond the range saturates (SATURATE=1) or wraps, and sets OVF.
- **Latency.** The last sample of a dot product accepted on edge t gives out_valid=1 after edge t+3, provided there are no stalls. Throughput is 1 sample per cycle.
- **Output handshake.**
  - out_valid && out_ready on an edge with no new termination: out_valid becomes 0.
  - out_valid && out_ready on an edge with a new termination: the new result loads and out_valid stays 1. No gap and no loss.
  - P, OVF and CNT are stable while out_valid && !out_ready.
- **MODE.** MODE is captured per sample; changing MODE mid dot product is legal.
- **Reset mid-operation.** A partial accumulation and any pending result are discarded. After RST_N rises, the first accepted sample starts a new dot product.
- **Boundary cases.**
  - ACC_LEN=1: every sample produces a result.
  - in_last on the first sample gives CNT=1.

Test Plan:
- **Basic dot product.** ACC_LEN=4, MODE=01, A=2, B=3, D=5, 4 consecutive samples, out_ready=1 -> single result P=64, CNT=4, OVF=0, out_valid 3 edges after the 4th accept.
- **Subtract mode and early termination.** MODE=10, A=-4, D=5, B=3, in_last on 2nd sample -> P=-16, CNT=2. The next 4 samples (MODE=00, A=1, B=1) -> P=4, CNT=4.
- **Saturation.** P_WIDTH=37, ACC_LEN=4, MODE=10, A=-131072, D=-131072, B=131071, 4 samples -> P=68719476735, OVF=1. With SATURATE=0 the wrapped value is checked against the model and OVF=1.
- **Rounding.** ROUND_SHIFT=2, ACC_LEN=1, MODE=00: A=5, B=2 -> P=3; A=-5, B=2 -> P=-2.
- **Backpressure.**
  - Stream ACC_LEN=1 samples with out_ready held 0 -> in_ready drops once out_valid=1, and P holds.
  - Toggle out_ready every cycle -> no result is lost or duplicated (scoreboard), and back-to-back results occur with out_valid staying high.
- **Reset and CE.**
  - Drop RST_N for 1 cycle after 2 of 4 samples -> no output. The next 4 samples give a clean result.
  - CE=0 for 3 cycles mid-stream -> all outputs frozen, and the final result is unchanged versus the no-stall run.
